scan_decoder: RTL

//  Parametrised, registered one-hot decoder: SEL_W-bit index -> 2**SEL_W select lines.
//  Two modes. DIRECT registers the decode of sel_in. SCAN self-sequences through the

---
 rtl/scan_decoder_pkg.sv | 22 ++
 rtl/scan_decoder_if.sv | 30 +++
 rtl/scan_decoder_next_set_idx.sv | 30 +++
 rtl/scan_decoder.sv | 108 ++++++++++
 4 files changed

// File: rtl/scan_decoder_pkg.sv
// Shared types and constants for the scan_decoder block: mode codes, FSM encoding
// and the constant clog2 used to size the slot prescaler.
package scan_decoder_pkg;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_DIRECT     = 2'd1,
      ST_SCAN_BLANK = 2'd2,
      ST_SCAN_DRIVE = 2'd3
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) r++;
      return r;
   endfunction

endpackage

// File: rtl/scan_decoder_if.sv
// Control and select bus of scan_decoder; the block is the slave, the CPU I/O logic the master.
interface scan_decoder_if #(
   parameter int SEL_W = 3
);
   import scan_decoder_pkg::*;

   localparam int N = 1 << SEL_W;

   // No valid/ready handshake: every control input is a level sampled on each rising
   // clock edge, and every output is a registered level valid for the whole cycle.
   logic             en;
   logic             mode;
   logic [SEL_W-1:0] sel_in;
   logic [N-1:0]     mask;
   logic [N-1:0]     y;
   logic [SEL_W-1:0] cur_sel;
   logic             slot_start;
   state_t           state;

   modport master (
      output en, mode, sel_in, mask,
      input  y, cur_sel, slot_start, state
   );

   modport slave (
      input  en, mode, sel_in, mask,
      output y, cur_sel, slot_start, state
   );

endinterface

// File: rtl/scan_decoder_next_set_idx.sv
// Circular first-set-bit search starting one past cur; wraps back onto cur itself last,
// so a lone set bit at cur yields cur and an empty mask yields any = 0.
module next_set_idx #(
   parameter int SEL_W = 3
) (
   input  logic [SEL_W-1:0]        cur,
   input  logic [(1 << SEL_W)-1:0] mask,
   output logic [SEL_W-1:0]        nxt,
   output logic                    any
);

   localparam int N = 1 << SEL_W;

   logic [SEL_W-1:0] idx;

   // Scan from the farthest offset down so the nearest set bit is written last and wins.
   always_comb begin
      nxt = cur;
      any = 1'b0;
      idx = '0;
      for (int k = N; k >= 1; k--) begin
         idx = cur + SEL_W'(k);
         if (mask[idx]) begin
            nxt = idx;
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot select decoder with a DIRECT mode and a self-sequencing SCAN mode
// (prescaled slots, leading blanking window, masked outputs skipped).
module scan_decoder
   import scan_decoder_pkg::*;
#(
   parameter int SEL_W      = 3,
   parameter int PRESCALE   = 100000,
   parameter int BLANK      = 16,
   parameter int ACTIVE_LOW = 1
) (
   input logic           clk,
   input logic           rst_n,
   scan_decoder_if.slave bus
);

   localparam int N  = 1 << SEL_W;
   localparam int PW = (PRESCALE > 1) ? clog2(PRESCALE) : 1;

   localparam logic [PW-1:0] BLANK_TERM = PW'((BLANK > 0) ? BLANK - 1 : 0);
   localparam logic [PW-1:0] SLOT_TERM  = PW'(PRESCALE - 1);
   localparam state_t        SLOT_FIRST = (BLANK == 0) ? ST_SCAN_DRIVE : ST_SCAN_BLANK;
   localparam logic [N-1:0]  Y_OFF      = {N{ACTIVE_LOW != 0}};

   state_t           state, state_nxt;
   logic [PW-1:0]    presc, presc_nxt;
   logic [SEL_W-1:0] cur_sel, cur_sel_nxt;
   logic             slot_start, slot_start_nxt;
   logic [N-1:0]     y, y_nxt;
   logic [N-1:0]     onehot;
   logic [SEL_W-1:0] search_nxt;
   logic             search_any;

   next_set_idx #(.SEL_W(SEL_W)) u_next (
      .cur  (cur_sel),
      .mask (bus.mask),
      .nxt  (search_nxt),
      .any  (search_any)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         presc      <= '0;
         cur_sel    <= '0;
         slot_start <= 1'b0;
         y          <= Y_OFF;
      end else begin
         state      <= state_nxt;
         presc      <= presc_nxt;
         cur_sel    <= cur_sel_nxt;
         slot_start <= slot_start_nxt;
         y          <= y_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      presc_nxt      = presc;
      cur_sel_nxt    = cur_sel;
      slot_start_nxt = 1'b0;
      if (!bus.en) begin
         state_nxt = ST_IDLE;
      end else if (bus.mode == MODE_DIRECT) begin
         state_nxt   = ST_DIRECT;
         cur_sel_nxt = bus.sel_in;
         presc_nxt   = '0;
      end else begin
         unique case (state)
            ST_IDLE, ST_DIRECT: begin
               state_nxt      = SLOT_FIRST;
               cur_sel_nxt    = bus.sel_in;
               presc_nxt      = '0;
               slot_start_nxt = 1'b1;
            end
            ST_SCAN_BLANK: begin
               presc_nxt = presc + 1'b1;
               if (presc == BLANK_TERM) state_nxt = ST_SCAN_DRIVE;
            end
            ST_SCAN_DRIVE: begin
               // Slot boundary: advance to the next enabled output, or stay put if none.
               if (presc == SLOT_TERM) begin
                  state_nxt      = SLOT_FIRST;
                  presc_nxt      = '0;
                  cur_sel_nxt    = search_any ? search_nxt : cur_sel;
                  slot_start_nxt = 1'b1;
               end else begin
                  presc_nxt = presc + 1'b1;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // y is decoded from the next-cycle state and index so it lands in the same flop stage.
   always_comb begin
      onehot = '0;
      onehot[cur_sel_nxt] = ((state_nxt == ST_DIRECT) || (state_nxt == ST_SCAN_DRIVE))
                            && bus.mask[cur_sel_nxt];
      y_nxt = (ACTIVE_LOW != 0) ? ~onehot : onehot;
   end

   assign bus.y          = y;
   assign bus.cur_sel    = cur_sel;
   assign bus.slot_start = slot_start;
   assign bus.state      = state;

endmodule
